// File: rtl/k005297_pgrange_chk.sv
// k005297_pgrange_chk
//   Serial page-range checker for N bubble page channels. Each channel's
//   page number arrives LSB first alongside serial lower/upper bound streams.
//   The bits are compared during a rotating slot frame. At LATCH_POS every
//   page is classified and an access-invalid flag is latched. At FLAG_POS
//   the valid-page flag-set strobe is issued and invalid accesses are
//   counted with a saturating counter.
//
//   Optional build macro K005297_PGCHK_CAPTURE_EN records the page and the
//   channel of the lowest-index invalid access at FLAG_POS. When the macro
//   is undefined, those ports are tied to 0.
//
// Ports
//   i_MCLK, i_RST          master clock, synchronous active-high reset
//   i_CLK2M_PCEN_n         active-low clock enable; state advances only when low
//   i_FRAME_START_n        low on the enable cycle that is slot 0
//   i_PG_SR_LSB[NUM_CH]    per-channel serial page bit
//   i_LIMLO_LSB/HI_LSB     serial lower/upper bound bits
//   i_MODE                 00 eq-zero, 01 gte-lower, 10 outside [lo,hi], 11 off
//   i_UMODE_n              user mode (active low); checking armed when low
//   i_PGCMP_EQ[NUM_CH]     per-channel page-compare match
//   i_CNT_CLR              clears invalid counter (and capture registers)
//   o_ACC_INVAL_n          access-invalid, active low
//   o_VALPG_FLAG_SET_n     valid-page flag-set strobe, active low
//   o_INVAL_CNT            saturating invalid-access count
//   o_CMP_DONE             one enable period after the LATCH_POS update
//   o_LAST_INVAL_PG/CH     last captured invalid page / channel

// Per-channel serial magnitude compare and access-invalid flag.
module k005297_pgrange_lane (
    input  logic       i_MCLK,
    input  logic       i_RST,
    input  logic       en,
    input  logic       first,
    input  logic       active,
    input  logic       latch,
    input  logic       p,
    input  logic       lo,
    input  logic       hi,
    input  logic [1:0] mode,
    input  logic       umode_n,
    output logic       acc_inval
);
    logic ge_lo, le_hi, zero, inval;

    // The bit that differs most recently (highest significance so far)
    // decides each relation; equal bits leave it untouched.
    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            ge_lo     <= 1'b0;
            le_hi     <= 1'b0;
            zero      <= 1'b0;
            acc_inval <= 1'b0;
        end else if (en) begin
            if (first) begin
                ge_lo <= p | ~lo;
                le_hi <= ~p | hi;
                zero  <= ~p;
            end else if (active) begin
                if (p != lo) ge_lo <= p;
                if (p != hi) le_hi <= ~p;
                zero <= zero & ~p;
            end
            if (latch)        acc_inval <= inval & ~umode_n;
            else if (umode_n) acc_inval <= 1'b0;
        end
    end

    always_comb begin
        inval = 1'b0;
        case (mode)
            2'b00:   inval = zero;
            2'b01:   inval = ge_lo;
            2'b10:   inval = ~(ge_lo & le_hi);
            default: inval = 1'b0;
        endcase
    end
endmodule

module k005297_pgrange_chk #(
    parameter int PG_WIDTH  = 12,
    parameter int NUM_CH    = 2,
    parameter int FRAME_LEN = 20,
    parameter int LATCH_POS = 12,
    parameter int FLAG_POS  = 14
) (
    input  logic                i_MCLK,
    input  logic                i_RST,
    input  logic                i_CLK2M_PCEN_n,
    input  logic                i_FRAME_START_n,
    input  logic [NUM_CH-1:0]   i_PG_SR_LSB,
    input  logic                i_LIMLO_LSB,
    input  logic                i_LIMHI_LSB,
    input  logic [1:0]          i_MODE,
    input  logic                i_UMODE_n,
    input  logic [NUM_CH-1:0]   i_PGCMP_EQ,
    input  logic                i_CNT_CLR,
    output logic [NUM_CH-1:0]   o_ACC_INVAL_n,
    output logic [NUM_CH-1:0]   o_VALPG_FLAG_SET_n,
    output logic [7:0]          o_INVAL_CNT,
    output logic                o_CMP_DONE,
    output logic [PG_WIDTH-1:0] o_LAST_INVAL_PG,
    output logic [1:0]          o_LAST_INVAL_CH
);
    localparam int SLOT_W = $clog2(FRAME_LEN);

    logic [SLOT_W-1:0] slot_q, cur_slot;
    logic              synced_q;
    logic              en, first, active, latch, at_flag;
    logic [NUM_CH-1:0] acc_inval, hit;
    logic [2:0]        n_hit;
    logic [8:0]        cnt_sum;

    // A frame start makes the current enable slot 0, so a mid-frame start
    // re-initialises the compare and the aborted frame never reaches latch.
    assign en       = ~i_CLK2M_PCEN_n;
    assign cur_slot = i_FRAME_START_n ? slot_q : '0;
    assign first    = (cur_slot == '0);
    assign active   = (cur_slot < SLOT_W'(PG_WIDTH));
    assign latch    = (cur_slot == SLOT_W'(LATCH_POS)) && synced_q;
    assign at_flag  = (cur_slot == SLOT_W'(FLAG_POS));

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            slot_q   <= '0;
            synced_q <= 1'b0;
        end else if (en) begin
            slot_q <= (cur_slot == SLOT_W'(FRAME_LEN-1)) ? '0 : cur_slot + 1'b1;
            if (!i_FRAME_START_n) synced_q <= 1'b1;
        end
    end

    k005297_pgrange_lane u_lane [NUM_CH-1:0] (
        .i_MCLK    (i_MCLK),
        .i_RST     (i_RST),
        .en        (en),
        .first     (first),
        .active    (active),
        .latch     (latch),
        .p         (i_PG_SR_LSB),
        .lo        (i_LIMLO_LSB),
        .hi        (i_LIMHI_LSB),
        .mode      (i_MODE),
        .umode_n   (i_UMODE_n),
        .acc_inval (acc_inval)
    );

    assign hit           = acc_inval & i_PGCMP_EQ;
    assign o_ACC_INVAL_n = ~hit;

    always_comb begin
        n_hit = '0;
        for (int c = 0; c < NUM_CH; c++) n_hit = n_hit + 3'(hit[c]);
    end
    assign cnt_sum = {1'b0, o_INVAL_CNT} + 9'(n_hit);

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            o_VALPG_FLAG_SET_n <= '1;
            o_INVAL_CNT        <= '0;
            o_CMP_DONE         <= 1'b0;
        end else if (en) begin
            o_VALPG_FLAG_SET_n <= ~({NUM_CH{at_flag}} & i_PGCMP_EQ & ~acc_inval);
            o_CMP_DONE         <= latch;
            if (i_CNT_CLR)    o_INVAL_CNT <= '0;
            else if (at_flag) o_INVAL_CNT <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

`ifdef K005297_PGCHK_CAPTURE_EN
    logic [NUM_CH-1:0][PG_WIDTH-1:0] cap_sr;
    logic [PG_WIDTH-1:0]             sel_pg;
    logic [1:0]                      sel_ch;

    // Walk downward so the lowest-index invalid channel wins.
    always_comb begin
        sel_pg = '0;
        sel_ch = '0;
        for (int c = NUM_CH-1; c >= 0; c--) begin
            if (hit[c]) begin
                sel_pg = cap_sr[c];
                sel_ch = 2'(c);
            end
        end
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            cap_sr          <= '0;
            o_LAST_INVAL_PG <= '0;
            o_LAST_INVAL_CH <= '0;
        end else if (en) begin
            // LSB arrives first, so shift in from the top.
            if (active)
                for (int c = 0; c < NUM_CH; c++)
                    cap_sr[c] <= {i_PG_SR_LSB[c], cap_sr[c][PG_WIDTH-1:1]};
            if (i_CNT_CLR) begin
                o_LAST_INVAL_PG <= '0;
                o_LAST_INVAL_CH <= '0;
            end else if (at_flag && |hit) begin
                o_LAST_INVAL_PG <= sel_pg;
                o_LAST_INVAL_CH <= sel_ch;
            end
        end
    end
`else
    assign o_LAST_INVAL_PG = '0;
    assign o_LAST_INVAL_CH = '0;
`endif
endmodule
